// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller for the 5-stage RV32I pipeline.
// Decides each cycle which stage registers hold, which take a bubble, and when a
// mispredict redirect is accepted. Also tracks dmem wait timeouts, halts on
// SYSTEM instructions, and counts stall cycles and accepted redirects.
module pipe_ctrl #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [6:0]  D_opcode_i,
   input  logic [4:0]  D_rs1_i,
   input  logic [4:0]  D_rs2_i,
   input  logic [6:0]  E_opcode_i,
   input  logic [4:0]  E_rd_i,
   input  logic        E_redirect_i,
   input  logic        M_mem_i,
   input  logic        dmem_ready_i,
   input  logic [6:0]  W_opcode_i,
   output logic        F_stall_o,
   output logic        D_stall_o,
   output logic        E_stall_o,
   output logic        M_stall_o,
   output logic        D_bubble_o,
   output logic        E_bubble_o,
   output logic        W_bubble_o,
   output logic        redirect_o,
   output logic        halt_o,
   output logic        bus_err_o,
   output logic [31:0] cnt_stall_o,
   output logic [31:0] cnt_flush_o
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   typedef enum logic [1:0] {
      S_RUN,
      S_MWAIT,
      S_HALT,
      S_ERR
   } state_t;

   state_t      r_state;
   logic [7:0]  r_waitCnt;
   logic        r_halt;
   logic        r_busErr;
   logic [31:0] r_cntStall;
   logic [31:0] r_cntFlush;

   logic        w_rs1Used;
   logic        w_rs2Used;
   logic        w_loadUse;
   logic        w_frozen;
   logic        w_stopped;
   logic [7:0]  w_waitNext;
   logic        w_fStall;
   logic        w_dStall;
   logic        w_eStall;
   logic        w_mStall;
   logic        w_dBubble;
   logic        w_eBubble;
   logic        w_wBubble;
   logic        w_redirect;

   // Hazard detection: which D sources are real, and whether a load in E feeds one of them.
   always_comb begin
      w_rs1Used  = (D_opcode_i == OP_JALR)  || (D_opcode_i == OP_BRANCH) ||
                   (D_opcode_i == OP_LOAD)  || (D_opcode_i == OP_STORE)  ||
                   (D_opcode_i == OP_IMM)   || (D_opcode_i == OP_R);
      w_rs2Used  = (D_opcode_i == OP_BRANCH) || (D_opcode_i == OP_STORE) ||
                   (D_opcode_i == OP_R);
      w_loadUse  = (E_opcode_i == OP_LOAD) && (E_rd_i != 5'd0) &&
                   ((w_rs1Used && (D_rs1_i == E_rd_i)) ||
                    (w_rs2Used && (D_rs2_i == E_rd_i)));
      w_stopped  = (r_state == S_HALT) || (r_state == S_ERR);
      w_frozen   = ((r_state == S_RUN) || (r_state == S_MWAIT)) &&
                   M_mem_i && !dmem_ready_i;
      w_waitNext = (r_waitCnt == MAX_WAIT_C) ? r_waitCnt : r_waitCnt + 8'd1;
   end

   // Per-cycle control decision in priority order; everything is held low while reset is asserted
   // so the pipeline sees a clean idle controller the moment reset hits.
   always_comb begin
      w_fStall   = 1'b0;
      w_dStall   = 1'b0;
      w_eStall   = 1'b0;
      w_mStall   = 1'b0;
      w_dBubble  = 1'b0;
      w_eBubble  = 1'b0;
      w_wBubble  = 1'b0;
      w_redirect = 1'b0;
      if (!rst_n_i) begin
         w_fStall = 1'b0;
      end else if (w_stopped || w_frozen) begin
         w_fStall  = 1'b1;
         w_dStall  = 1'b1;
         w_eStall  = 1'b1;
         w_mStall  = 1'b1;
         w_wBubble = 1'b1;
      end else if (E_redirect_i) begin
         w_redirect = 1'b1;
         w_dBubble  = 1'b1;
         w_eBubble  = 1'b1;
      end else if (w_loadUse) begin
         w_fStall  = 1'b1;
         w_dStall  = 1'b1;
         w_eBubble = 1'b1;
      end
   end

   // Sequencing FSM: memory wait tracking with timeout, halt on SYSTEM, sticky halt/error flags.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state   <= S_RUN;
         r_waitCnt <= 8'd0;
         r_halt    <= 1'b0;
         r_busErr  <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (w_frozen) begin
                  r_state   <= S_MWAIT;
                  r_waitCnt <= 8'd0;
               end else if (W_opcode_i == OP_SYSTEM) begin
                  r_state <= S_HALT;
                  r_halt  <= 1'b1;
               end
            end
            S_MWAIT: begin
               if (w_frozen) begin
                  r_waitCnt <= w_waitNext;
                  if (w_waitNext >= MAX_WAIT_C) begin
                     r_state  <= S_ERR;
                     r_halt   <= 1'b1;
                     r_busErr <= 1'b1;
                  end
               end else begin
                  r_state <= S_RUN;
               end
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_state <= S_ERR;
            end
         endcase
      end
   end

   // Performance counters: stall cycles and accepted redirects, frozen once the core stops.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cntStall <= 32'd0;
         r_cntFlush <= 32'd0;
      end else if (!w_stopped) begin
         if (w_fStall) begin
            r_cntStall <= r_cntStall + 32'd1;
         end
         if (w_redirect) begin
            r_cntFlush <= r_cntFlush + 32'd1;
         end
      end
   end

   assign F_stall_o   = w_fStall;
   assign D_stall_o   = w_dStall;
   assign E_stall_o   = w_eStall;
   assign M_stall_o   = w_mStall;
   assign D_bubble_o  = w_dBubble;
   assign E_bubble_o  = w_eBubble;
   assign W_bubble_o  = w_wBubble;
   assign redirect_o  = w_redirect;
   assign halt_o      = r_halt;
   assign bus_err_o   = r_busErr;
   assign cnt_stall_o = r_cntStall;
   assign cnt_flush_o = r_cntFlush;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl with a short memory timeout.
// A table of single-cycle vectors covers the hazard priorities, hand sequences cover
// the multi-cycle corners, and a random run is checked against a cycle-level model.
module tb_pipe_ctrl;

   localparam int MAX_WAIT = 4;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // Control vector packing: {F,D,E,M stall, D,E,W bubble, redirect}
   localparam logic [7:0] C_IDLE   = 8'h00;
   localparam logic [7:0] C_FREEZE = 8'hF2;
   localparam logic [7:0] C_REDIR  = 8'h0D;
   localparam logic [7:0] C_LDUSE  = 8'hC4;

   typedef struct {
      logic [6:0] dOp;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [6:0] eOp;
      logic [4:0] eRd;
      logic       eRedirect;
      logic       mMem;
      logic       ready;
      logic [6:0] wOp;
   } stim_t;

   typedef struct {
      string      name;
      stim_t      s;
      logic [7:0] expCtrl;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [6:0]  dOp;
   logic [4:0]  dRs1;
   logic [4:0]  dRs2;
   logic [6:0]  eOp;
   logic [4:0]  eRd;
   logic        eRedirect;
   logic        mMem;
   logic        dmemReady;
   logic [6:0]  wOp;
   logic        fStall, dStall, eStall, mStall;
   logic        dBubble, eBubble, wBubble, redirect;
   logic        halt, busErr;
   logic [31:0] cntStall, cntFlush;
   logic [7:0]  ctrl;

   int nTests = 0;
   int nFail  = 0;

   // Reference model state, described in terms of observable behaviour
   bit          mHalted;
   bit          mErr;
   bit          mPrevFrozen;
   int          mStreak;
   bit [31:0]   mCntStall;
   bit [31:0]   mCntFlush;

   pipe_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .D_opcode_i   (dOp),
      .D_rs1_i      (dRs1),
      .D_rs2_i      (dRs2),
      .E_opcode_i   (eOp),
      .E_rd_i       (eRd),
      .E_redirect_i (eRedirect),
      .M_mem_i      (mMem),
      .dmem_ready_i (dmemReady),
      .W_opcode_i   (wOp),
      .F_stall_o    (fStall),
      .D_stall_o    (dStall),
      .E_stall_o    (eStall),
      .M_stall_o    (mStall),
      .D_bubble_o   (dBubble),
      .E_bubble_o   (eBubble),
      .W_bubble_o   (wBubble),
      .redirect_o   (redirect),
      .halt_o       (halt),
      .bus_err_o    (busErr),
      .cnt_stall_o  (cntStall),
      .cnt_flush_o  (cntFlush)
   );

   assign ctrl = {fStall, dStall, eStall, mStall, dBubble, eBubble, wBubble, redirect};

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic stim_t mk(input logic [6:0] d, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [6:0] e, input logic [4:0] rd, input logic red,
                                input logic mm, input logic rdy, input logic [6:0] w);
      stim_t s;
      s.dOp = d; s.rs1 = r1; s.rs2 = r2; s.eOp = e; s.eRd = rd;
      s.eRedirect = red; s.mMem = mm; s.ready = rdy; s.wOp = w;
      return s;
   endfunction

   // Expected controls straight from the priority rules
   function automatic logic [7:0] modelCtrl(input stim_t s);
      bit useRs1, useRs2, hazard;
      useRs1 = s.dOp inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_R};
      useRs2 = s.dOp inside {OP_BRANCH, OP_STORE, OP_R};
      hazard = (s.eOp == OP_LOAD) && (s.eRd != 0) &&
               ((useRs1 && s.rs1 == s.eRd) || (useRs2 && s.rs2 == s.eRd));
      if (mHalted || mErr)         return C_FREEZE;
      if (s.mMem && !s.ready)      return C_FREEZE;
      if (s.eRedirect)             return C_REDIR;
      if (hazard)                  return C_LDUSE;
      return C_IDLE;
   endfunction

   // Advance the model by one clock edge. A freeze streak starts in RUN, so the
   // error trips once the streak is one longer than the allowed number of wait cycles.
   task automatic modelStep(input stim_t s);
      logic [7:0] c;
      bit frozen;
      c = modelCtrl(s);
      if (!(mHalted || mErr)) begin
         if (c[7]) mCntStall = mCntStall + 1;
         if (c[0]) mCntFlush = mCntFlush + 1;
         frozen = s.mMem && !s.ready;
         if (frozen) begin
            mStreak = mStreak + 1;
            if (mStreak == MAX_WAIT + 1) mErr = 1;
         end else begin
            if (!mPrevFrozen && s.wOp == OP_SYSTEM) mHalted = 1;
            mStreak = 0;
         end
         mPrevFrozen = frozen;
      end
   endtask

   task automatic modelReset();
      mHalted = 0; mErr = 0; mPrevFrozen = 0; mStreak = 0;
      mCntStall = 0; mCntFlush = 0;
   endtask

   task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nTests++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input stim_t s);
      dOp = s.dOp; dRs1 = s.rs1; dRs2 = s.rs2; eOp = s.eOp; eRd = s.eRd;
      eRedirect = s.eRedirect; mMem = s.mMem; dmemReady = s.ready; wOp = s.wOp;
   endtask

   task automatic checkOutput(input string tag, input stim_t s);
      checkVal({tag, " ctrl"},     {24'd0, ctrl}, {24'd0, modelCtrl(s)});
      checkVal({tag, " status"},   {30'd0, halt, busErr}, {30'd0, (mHalted || mErr), mErr});
      checkVal({tag, " cntStall"}, cntStall, mCntStall);
      checkVal({tag, " cntFlush"}, cntFlush, mCntFlush);
   endtask

   // One cycle: drive at the falling edge, check mid-cycle, step model at the rising edge
   task automatic runCycle(input stim_t s, input string tag);
      applyStimulus(s);
      #1;
      checkOutput(tag, s);
      @(posedge clk);
      modelStep(s);
      @(negedge clk);
   endtask

   // Assert reset with the current inputs still applied; outputs must drop at once
   task automatic doReset();
      rst_n = 1'b0;
      #1;
      checkVal("reset ctrl",     {24'd0, ctrl}, 32'd0);
      checkVal("reset status",   {30'd0, halt, busErr}, 32'd0);
      checkVal("reset cntStall", cntStall, 32'd0);
      checkVal("reset cntFlush", cntFlush, 32'd0);
      modelReset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic stim_t randStim();
      logic [6:0] ops [10];
      stim_t s;
      ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_R, OP_R};
      s.dOp       = ops[$urandom_range(0, 9)];
      s.rs1       = 5'($urandom_range(0, 7));
      s.rs2       = 5'($urandom_range(0, 7));
      s.eOp       = ($urandom_range(0, 1) == 0) ? OP_LOAD : ops[$urandom_range(0, 9)];
      s.eRd       = 5'($urandom_range(0, 7));
      s.eRedirect = ($urandom_range(0, 5) == 0);
      s.mMem      = ($urandom_range(0, 2) == 0);
      s.ready     = ($urandom_range(0, 2) != 0);
      s.wOp       = ($urandom_range(0, 39) == 0) ? OP_SYSTEM : ops[$urandom_range(0, 9)];
      return s;
   endfunction

   vec_t  vecs[$];
   stim_t st;
   stim_t idle;

   initial begin
      idle = mk(OP_R, 5'd0, 5'd0, OP_R, 5'd0, 1'b0, 1'b0, 1'b0, OP_R);
      applyStimulus(idle);
      rst_n = 1'b0;
      modelReset();
      @(negedge clk);
      doReset();

      // Single-cycle priority vectors, applied back to back from RUN
      vecs.push_back('{"lduse rs2 R",     mk(OP_R,      5'd1, 5'd5, OP_LOAD, 5'd5, 0, 0, 0, OP_R), C_LDUSE});
      vecs.push_back('{"lduse rd0",       mk(OP_R,      5'd0, 5'd0, OP_LOAD, 5'd0, 0, 0, 0, OP_R), C_IDLE});
      vecs.push_back('{"lduse LUI",       mk(OP_LUI,    5'd5, 5'd5, OP_LOAD, 5'd5, 0, 0, 0, OP_R), C_IDLE});
      vecs.push_back('{"lduse rs1 IMM",   mk(OP_IMM,    5'd5, 5'd1, OP_LOAD, 5'd5, 0, 0, 0, OP_R), C_LDUSE});
      vecs.push_back('{"rs2 unused IMM",  mk(OP_IMM,    5'd3, 5'd5, OP_LOAD, 5'd5, 0, 0, 0, OP_R), C_IDLE});
      vecs.push_back('{"lduse rs2 BR",    mk(OP_BRANCH, 5'd2, 5'd5, OP_LOAD, 5'd5, 0, 0, 0, OP_R), C_LDUSE});
      vecs.push_back('{"lduse rs2 ST",    mk(OP_STORE,  5'd2, 5'd7, OP_LOAD, 5'd7, 0, 0, 0, OP_R), C_LDUSE});
      vecs.push_back('{"lduse rs1 JALR",  mk(OP_JALR,   5'd6, 5'd0, OP_LOAD, 5'd6, 0, 0, 0, OP_R), C_LDUSE});
      vecs.push_back('{"JAL no sources",  mk(OP_JAL,    5'd6, 5'd6, OP_LOAD, 5'd6, 0, 0, 0, OP_R), C_IDLE});
      vecs.push_back('{"E not load",      mk(OP_R,      5'd5, 5'd5, OP_R,    5'd5, 0, 0, 0, OP_R), C_IDLE});
      vecs.push_back('{"redir over ld",   mk(OP_R,      5'd5, 5'd5, OP_LOAD, 5'd5, 1, 0, 0, OP_R), C_REDIR});
      vecs.push_back('{"freeze over all", mk(OP_R,      5'd5, 5'd5, OP_LOAD, 5'd5, 1, 1, 0, OP_R), C_FREEZE});
      vecs.push_back('{"ready ends frz",  mk(OP_R,      5'd5, 5'd5, OP_LOAD, 5'd5, 0, 1, 1, OP_R), C_LDUSE});
      vecs.push_back('{"mem ready idle",  mk(OP_R,      5'd1, 5'd2, OP_R,    5'd3, 0, 1, 1, OP_R), C_IDLE});
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].s);
         #1;
         checkVal(vecs[i].name, {24'd0, ctrl}, {24'd0, vecs[i].expCtrl});
         checkOutput(vecs[i].name, vecs[i].s);
         @(posedge clk);
         modelStep(vecs[i].s);
         @(negedge clk);
      end

      // Load-use costs one cycle; the dependent instruction then moves on
      doReset();
      runCycle(mk(OP_R, 5'd1, 5'd5, OP_LOAD, 5'd5, 0, 0, 0, OP_R), "lu seq 1");
      runCycle(mk(OP_IMM, 5'd2, 5'd0, OP_R, 5'd5, 0, 1, 1, OP_R), "lu seq 2");
      checkVal("lu cntStall", cntStall, 32'd1);

      // Mispredict wins over a simultaneous load-use
      doReset();
      runCycle(mk(OP_R, 5'd5, 5'd5, OP_LOAD, 5'd5, 1, 0, 0, OP_R), "mp seq");
      checkVal("mp cntFlush", cntFlush, 32'd1);
      checkVal("mp cntStall", cntStall, 32'd0);

      // Three frozen cycles with a pending redirect, accepted in the ready cycle
      doReset();
      st = mk(OP_R, 5'd0, 5'd0, OP_R, 5'd0, 1, 1, 0, OP_R);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(st);
         #1;
         checkVal("frz pending", {24'd0, ctrl}, {24'd0, C_FREEZE});
         @(posedge clk);
         modelStep(st);
         @(negedge clk);
      end
      st.ready = 1'b1;
      applyStimulus(st);
      #1;
      checkVal("frz release", {24'd0, ctrl}, {24'd0, C_REDIR});
      @(posedge clk);
      modelStep(st);
      @(negedge clk);
      checkVal("frz cntFlush", cntFlush, 32'd1);
      checkVal("frz cntStall", cntStall, 32'd3);

      // Timeout: five frozen cycles reach the error, which then sticks
      doReset();
      st = mk(OP_R, 5'd0, 5'd0, OP_R, 5'd0, 0, 1, 0, OP_R);
      for (int i = 0; i < 4; i++) runCycle(st, "to wait");
      checkVal("to not yet", {31'd0, busErr}, 32'd0);
      runCycle(st, "to last");
      checkVal("to busErr", {31'd0, busErr}, 32'd1);
      checkVal("to halt", {31'd0, halt}, 32'd1);
      st = mk(OP_R, 5'd5, 5'd5, OP_LOAD, 5'd5, 1, 1, 1, OP_R);
      runCycle(st, "to sticky");
      checkVal("to sticky ctrl", {24'd0, ctrl}, {24'd0, C_FREEZE});
      checkVal("to cntStall", cntStall, 32'd5);
      doReset();

      // Halt on SYSTEM in W; counters freeze afterwards
      runCycle(mk(OP_R, 5'd0, 5'd0, OP_R, 5'd0, 0, 0, 0, OP_SYSTEM), "halt trig");
      checkVal("halt flag", {31'd0, halt}, 32'd1);
      checkVal("halt no err", {31'd0, busErr}, 32'd0);
      runCycle(mk(OP_R, 5'd5, 5'd5, OP_LOAD, 5'd5, 1, 0, 0, OP_R), "halted 1");
      runCycle(mk(OP_R, 5'd5, 5'd5, OP_LOAD, 5'd5, 0, 0, 0, OP_R), "halted 2");
      checkVal("halt cntStall", cntStall, 32'd0);
      checkVal("halt cntFlush", cntFlush, 32'd0);
      doReset();

      // Reset mid-MWAIT while the freeze inputs are still applied
      st = mk(OP_R, 5'd0, 5'd0, OP_R, 5'd0, 0, 1, 0, OP_R);
      runCycle(st, "mw 1");
      runCycle(st, "mw 2");
      doReset();
      runCycle(mk(OP_R, 5'd1, 5'd5, OP_LOAD, 5'd5, 0, 0, 0, OP_R), "post reset lu");

      // Random traffic against the model; reset whenever the core has stopped for a while
      for (int n = 0; n < 1500; n++) begin
         runCycle(randStim(), "rand");
         if ((mHalted || mErr) && ($urandom_range(0, 3) == 0)) doReset();
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
